// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply-unit FSM encoding and the R-type
// funct codes that drive the HI/LO datapath.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

endpackage

// File: rtl/multiply_unit.sv
// Unsigned radix-2 shift-add multiplier for multu; one multiplier bit per
// cycle, product published to hi/lo only when the full run completes.
module multiply_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mul_state_t       state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is sampled only in IDLE or DONE; busy is high for the
  // WIDTH RUN cycles; done pulses for one cycle as hi/lo take the product.

  mul_state_t           state;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH:0]     acc;
  logic [CW-1:0]        cnt;
  logic [WIDTH:0]       upper_sum;
  logic [2*WIDTH:0]     acc_step;
  logic                 accept;

  // acc = {carry, upper half, multiplier/lower half}; the low bit is always
  // the current multiplier bit, and the top bit is zero before every add.
  always_comb begin
    upper_sum = acc[2*WIDTH:WIDTH];
    if (acc[0]) upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
    acc_step = {1'b0, upper_sum, acc[WIDTH-1:1]};
  end

  assign accept    = start && (state == IDLE || state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mcand <= srca;
        acc   <= {{(WIDTH + 1){1'b0}}, srcb};
        cnt   <= '0;
        busy  <= 1'b1;
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              hi    <= acc_step[2*WIDTH-1:WIDTH];
              lo    <= acc_step[WIDTH-1:0];
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
          DONE:    state <= IDLE;
          IDLE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multiply_unit.sv
// Bench for multiply_unit: directed multu vectors plus random pairs, with a
// queue-based scoreboard checking hi/lo on every done pulse.
module tb_multiply_unit;
  import mips_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  mul_state_t   state_dbg;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] prev_prod;
  int checks;
  int failures;

  multiply_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .srca      (srca),
    .srcb      (srcb),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input bit ok,
                       input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1'b0, {hi, lo}, '0);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("product", {hi, lo} === e, {hi, lo}, e);
      end
    end
  end

  // driver: issue one multu and track it until done (or an abort)
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] expv, input bit skip_sync,
                        input int ign_at, input int rst_at);
    int cyc;
    if (!skip_sync) @(negedge clk);
    start = 1'b1;
    srca  = a;
    srcb  = b;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
    srca  = $urandom;
    srcb  = $urandom;
    cyc   = 1;
    while (!done && cyc < 40) begin
      check("busy_in_run", busy === 1'b1, {63'b0, busy}, 64'd1);
      check("hold_prev", {hi, lo} === prev_prod, {hi, lo}, prev_prod);
      if (ign_at != 0 && cyc == ign_at) begin
        start = 1'b1;
        srca  = 32'd7;
        srcb  = 32'd7;
      end else if (ign_at != 0 && cyc == ign_at + 1) begin
        start = 1'b0;
      end
      if (cyc == rst_at) begin
        reset = 1'b1;
        #1;
        check("abort_busy", busy === 1'b0, {63'b0, busy}, 64'd0);
        check("abort_done", done === 1'b0, {63'b0, done}, 64'd0);
        check("abort_hilo", {hi, lo} === 64'd0, {hi, lo}, 64'd0);
        void'(exp_q.pop_back());
        prev_prod = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
          @(negedge clk);
          check("no_done_after_abort", done === 1'b0, {63'b0, done}, 64'd0);
        end
        return;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_latency", done === 1'b1 && cyc == 33, 64'(cyc), 64'd33);
    check("busy_low_at_done", busy === 1'b0, {63'b0, busy}, 64'd0);
    if (done !== 1'b1) void'(exp_q.pop_back());
    prev_prod = expv;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    checks    = 0;
    failures  = 0;
    prev_prod = '0;
    reset     = 1'b1;
    start     = 1'b0;
    srca      = '0;
    srcb      = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy === 1'b0, {63'b0, busy}, 64'd0);
    check("rst_done", done === 1'b0, {63'b0, done}, 64'd0);
    check("rst_hilo", {hi, lo} === 64'd0, {hi, lo}, 64'd0);
    check("rst_state", state_dbg === IDLE, 64'(state_dbg), 64'(IDLE));
    reset = 1'b0;

    // first edge with reset low accepts the start
    run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1, 0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 0, 0);
    run_op(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b0, 10, 0);
    run_op(32'd0, 32'd5, 64'd0, 1'b0, 0, 0);
    run_op(32'h1234_5678, 32'd0, 64'd0, 1'b0, 0, 0);
    run_op(32'd9, 32'd11, 64'd99, 1'b0, 0, 0);
    run_op(32'd6, 32'd7, 64'h0000_0000_0000_002A, 1'b1, 0, 0);
    run_op(32'hDEAD_BEEF, 32'h0000_1234, 64'd0, 1'b0, 0, 15);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 97 == 0) ra = '0;
      if (i % 89 == 0) rb = 32'hFFFF_FFFF;
      run_op(ra, rb, {32'b0, ra} * {32'b0, rb}, 1'($urandom_range(0, 1)), 0, 0);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
